// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller.
// Runs one word read or write per client request and drives the CE#/OE#/WE#
// strobes, the registered address and the bidirectional data bus.
// Every output is registered; the data bus is driven only during a write.
// Optional write-verify read-back is enabled by defining SRAM_WR_VERIFY_EN.
module sram_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_toread,
  input  logic              i_towrite,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_to_data,
  output logic [DATA_W-1:0] o_get_data,
  output logic              o_workdone,
  output logic              o_busy,
  output logic              o_verr,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_data,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n
);

  // A wait of zero cycles is treated as one
  localparam int WAIT_EFF = (WAIT_CYC < 1) ? 1 : WAIT_CYC;
  localparam int CNT_W    = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_SETUP,
    ST_RD_WAIT,
`ifdef SRAM_WR_VERIFY_EN
    ST_VRD_SETUP,
    ST_VRD_WAIT,
`endif
    ST_DONE,
    ST_RECOV
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_waitCnt;
  logic [DATA_W-1:0] r_wrData;
  logic              r_drive;
  logic [DATA_W-1:0] r_getData;
  logic              r_workdone;
  logic              r_busy;
  logic [ADDR_W-1:0] r_sramAddr;
  logic              r_ceN;
  logic              r_oeN;
  logic              r_weN;
`ifdef SRAM_WR_VERIFY_EN
  logic              r_verr;
`endif

  // Sequencer: one access per request, strobes and status updated on each transition
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_waitCnt  <= '0;
      r_wrData   <= '0;
      r_drive    <= 1'b0;
      r_getData  <= '0;
      r_workdone <= 1'b0;
      r_busy     <= 1'b0;
      r_sramAddr <= '0;
      r_ceN      <= 1'b1;
      r_oeN      <= 1'b1;
      r_weN      <= 1'b1;
`ifdef SRAM_WR_VERIFY_EN
      r_verr     <= 1'b0;
`endif
    end else begin
      r_workdone <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_towrite) begin
            r_state    <= ST_WR_SETUP;
            r_sramAddr <= i_addr;
            r_wrData   <= i_to_data;
            r_drive    <= 1'b1;
            r_ceN      <= 1'b0;
            r_busy     <= 1'b1;
          end else if (i_toread) begin
            r_state    <= ST_RD_SETUP;
            r_sramAddr <= i_addr;
            r_ceN      <= 1'b0;
            r_oeN      <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        ST_WR_SETUP: begin
          r_state   <= ST_WR_PULSE;
          r_weN     <= 1'b0;
          r_waitCnt <= CNT_LOAD;
        end
        ST_WR_PULSE: begin
          if (r_waitCnt == '0) begin
            r_state <= ST_WR_HOLD;
            r_weN   <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt - CNT_W'(1);
          end
        end
        ST_WR_HOLD: begin
`ifdef SRAM_WR_VERIFY_EN
          r_state <= ST_VRD_SETUP;
          r_drive <= 1'b0;
          r_oeN   <= 1'b0;
`else
          r_state    <= ST_DONE;
          r_workdone <= 1'b1;
          r_drive    <= 1'b0;
          r_ceN      <= 1'b1;
          r_oeN      <= 1'b1;
          r_weN      <= 1'b1;
`endif
        end
        ST_RD_SETUP: begin
          r_state   <= ST_RD_WAIT;
          r_waitCnt <= CNT_LOAD;
        end
        ST_RD_WAIT: begin
          if (r_waitCnt == '0) begin
            r_getData  <= io_sram_data;
            r_state    <= ST_DONE;
            r_workdone <= 1'b1;
            r_ceN      <= 1'b1;
            r_oeN      <= 1'b1;
            r_weN      <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt - CNT_W'(1);
          end
        end
`ifdef SRAM_WR_VERIFY_EN
        ST_VRD_SETUP: begin
          r_state   <= ST_VRD_WAIT;
          r_waitCnt <= CNT_LOAD;
        end
        ST_VRD_WAIT: begin
          if (r_waitCnt == '0) begin
            if (io_sram_data != r_wrData) begin
              r_verr <= 1'b1;
            end
            r_state    <= ST_DONE;
            r_workdone <= 1'b1;
            r_ceN      <= 1'b1;
            r_oeN      <= 1'b1;
            r_weN      <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt - CNT_W'(1);
          end
        end
`endif
        ST_DONE: begin
          r_state <= ST_RECOV;
        end
        ST_RECOV: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_drive <= 1'b0;
          r_busy  <= 1'b0;
          r_ceN   <= 1'b1;
          r_oeN   <= 1'b1;
          r_weN   <= 1'b1;
        end
      endcase
    end
  end

  assign io_sram_data = r_drive ? r_wrData : {DATA_W{1'bz}};
  assign o_get_data   = r_getData;
  assign o_workdone   = r_workdone;
  assign o_busy       = r_busy;
  assign o_sram_addr  = r_sramAddr;
  assign o_sram_ce_n  = r_ceN;
  assign o_sram_oe_n  = r_oeN;
  assign o_sram_we_n  = r_weN;
`ifdef SRAM_WR_VERIFY_EN
  assign o_verr       = r_verr;
`else
  assign o_verr       = 1'b0;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed self-checking bench for sram_ctrl with a small
// behavioural asynchronous SRAM model (256 words, address bits [7:0]).
module tb_sram_ctrl;

`ifdef SRAM_WR_VERIFY_EN
  localparam int WR_LAT = 8;
`else
  localparam int WR_LAT = 5;
`endif
  localparam int RD_LAT = 4;

  logic        clk;
  logic        rst;
  logic        toread;
  logic        towrite;
  logic [19:0] addr;
  logic [31:0] toData;
  logic [31:0] getData;
  logic        workdone;
  logic        busy;
  logic        verr;
  logic [19:0] sramAddr;
  wire  [31:0] sramData;
  logic        sramCeN;
  logic        sramOeN;
  logic        sramWeN;

  logic [31:0] mem [0:255];
  logic        corruptBit0;

  int compareCount;
  int mismatchCount;

  sram_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .i_toread    (toread),
    .i_towrite   (towrite),
    .i_addr      (addr),
    .i_to_data   (toData),
    .o_get_data  (getData),
    .o_workdone  (workdone),
    .o_busy      (busy),
    .o_verr      (verr),
    .o_sram_addr (sramAddr),
    .io_sram_data(sramData),
    .o_sram_ce_n (sramCeN),
    .o_sram_oe_n (sramOeN),
    .o_sram_we_n (sramWeN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: drives the bus while selected and output-enabled
  assign sramData = (!sramCeN && !sramOeN) ? mem[sramAddr[7:0]] : 32'hzzzz_zzzz;

  // SRAM model: latches the bus on the rising edge of WE#
  always @(posedge sramWeN) begin
    if (!sramCeN) mem[sramAddr[7:0]] <= sramData ^ {31'b0, corruptBit0};
  end

  // Hard stop in case something hangs despite the bounded loops
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    compareCount++;
    if (got !== expv) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and counts strobe activity until workdone or timeout
  task automatic applyStimulus(input logic wr, input logic rd, input logic [19:0] a,
                               input logic [31:0] d, input logic holdAfter,
                               output int doneCyc, output int weLow, output int oeLow,
                               output logic [19:0] seenAddr, output logic [31:0] seenBus);
    logic scrambled;
    towrite = wr;
    toread = rd;
    addr = a;
    toData = d;
    doneCyc = -1;
    weLow = 0;
    oeLow = 0;
    seenAddr = '0;
    seenBus = '0;
    scrambled = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      waitCycle();
      if (busy && !scrambled) begin
        addr = ~a;
        toData = ~d;
        scrambled = 1'b1;
      end
      if (!sramWeN) begin
        weLow++;
        seenAddr = sramAddr;
        seenBus = sramData;
      end
      if (!sramOeN) oeLow++;
      if (workdone) begin
        doneCyc = c;
        break;
      end
    end
    if (!holdAfter) begin
      towrite = 1'b0;
      toread = 1'b0;
    end
  endtask

  initial begin
    int doneCyc;
    int weLow;
    int oeLow;
    int wdCount;
    logic [19:0] seenAddr;
    logic [31:0] seenBus;
    logic allIdle;

    compareCount = 0;
    mismatchCount = 0;
    corruptBit0 = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    toread = 1'b0;
    towrite = 1'b0;
    addr = '0;
    toData = '0;

    // Reset, then ten quiet cycles
    rst = 1'b0;
    repeat (3) waitCycle();
    rst = 1'b1;
    allIdle = 1'b1;
    for (int i = 0; i < 10; i++) begin
      waitCycle();
      if ({sramCeN, sramOeN, sramWeN, workdone, busy} !== 5'b11100) allIdle = 1'b0;
      if (sramData !== 32'hzzzz_zzzz) allIdle = 1'b0;
    end
    checkOutput("idleStrobesBus", 64'(allIdle), 64'd1);
    checkOutput("resetAddr", 64'(sramAddr), 64'h0);
    checkOutput("resetGetData", 64'(getData), 64'h0);
    checkOutput("resetVerr", 64'(verr), 64'h0);

    // Write 0x5 to address 0
    applyStimulus(1'b1, 1'b0, 20'h0, 32'h5, 1'b0, doneCyc, weLow, oeLow, seenAddr, seenBus);
    checkOutput("wrLatency", 64'(doneCyc), 64'(WR_LAT));
    checkOutput("wrWeLowCycles", 64'(weLow), 64'd2);
    checkOutput("wrAddr", 64'(seenAddr), 64'h0);
    checkOutput("wrBus", 64'(seenBus), 64'h5);
    waitCycle();
    checkOutput("wrPulseOneCycle", 64'(workdone), 64'h0);
    checkOutput("recovBusy", 64'(busy), 64'h1);
    checkOutput("wrKeepsGetData", 64'(getData), 64'h0);
    waitCycle();
    checkOutput("idleAfterRecov", 64'(busy), 64'h0);

    // Read address 0 back
    applyStimulus(1'b0, 1'b1, 20'h0, 32'h0, 1'b0, doneCyc, weLow, oeLow, seenAddr, seenBus);
    checkOutput("rdLatency", 64'(doneCyc), 64'(RD_LAT));
    checkOutput("rdOeLowCycles", 64'(oeLow), 64'd3);
    checkOutput("rdData", 64'(getData), 64'h5);
    repeat (3) waitCycle();
    checkOutput("rdDataStable", 64'(getData), 64'h5);

    // Client overlap: write held one cycle past workdone, then a read
    applyStimulus(1'b1, 1'b0, 20'h3, 32'h33, 1'b1, doneCyc, weLow, oeLow, seenAddr, seenBus);
    checkOutput("ovWrLatency", 64'(doneCyc), 64'(WR_LAT));
    waitCycle();
    checkOutput("ovRecovWeHigh", 64'(sramWeN), 64'h1);
    applyStimulus(1'b0, 1'b1, 20'h3, 32'h0, 1'b0, doneCyc, weLow, oeLow, seenAddr, seenBus);
    checkOutput("ovNoSecondWrite", 64'(weLow), 64'd0);
    checkOutput("ovRdAcceptedNext", 64'(doneCyc), 64'(RD_LAT + 1));
    checkOutput("ovRdData", 64'(getData), 64'h33);
    repeat (2) waitCycle();

    // Both requests asserted: write wins
    applyStimulus(1'b1, 1'b1, 20'h12345, 32'hCAFEF00D, 1'b0, doneCyc, weLow, oeLow, seenAddr, seenBus);
    checkOutput("prioLatency", 64'(doneCyc), 64'(WR_LAT));
    checkOutput("prioWeLow", 64'(weLow), 64'd2);
    checkOutput("prioAddr", 64'(seenAddr), 64'h12345);
    checkOutput("prioBus", 64'(seenBus), 64'hCAFEF00D);
    checkOutput("prioKeepsGetData", 64'(getData), 64'h33);
    repeat (2) waitCycle();

    // Reset in the middle of the WE# pulse
    towrite = 1'b1;
    addr = 20'h40;
    toData = 32'h77;
    for (int i = 0; i < 10; i++) begin
      waitCycle();
      if (!sramWeN) break;
    end
    checkOutput("midWeLowReached", 64'(sramWeN), 64'h0);
    #2;
    rst = 1'b0;
    towrite = 1'b0;
    #1;
    checkOutput("midRstWe", 64'(sramWeN), 64'h1);
    checkOutput("midRstCe", 64'(sramCeN), 64'h1);
    checkOutput("midRstBusZ", 64'(sramData === 32'hzzzz_zzzz), 64'h1);
    checkOutput("midRstBusy", 64'(busy), 64'h0);
    repeat (2) waitCycle();
    rst = 1'b1;
    wdCount = 0;
    for (int i = 0; i < 8; i++) begin
      waitCycle();
      if (workdone) wdCount++;
    end
    checkOutput("midRstNoWorkdone", 64'(wdCount), 64'd0);

`ifdef SRAM_WR_VERIFY_EN
    // Verify read-back flags a corrupted bit and stays flagged
    corruptBit0 = 1'b1;
    applyStimulus(1'b1, 1'b0, 20'h7, 32'hA5A5A5A4, 1'b0, doneCyc, weLow, oeLow, seenAddr, seenBus);
    corruptBit0 = 1'b0;
    checkOutput("vfyLatency", 64'(doneCyc), 64'd8);
    checkOutput("vfyErrSet", 64'(verr), 64'h1);
    checkOutput("vfyKeepsGetData", 64'(getData), 64'h0);
    repeat (2) waitCycle();
    applyStimulus(1'b1, 1'b0, 20'h8, 32'h11, 1'b0, doneCyc, weLow, oeLow, seenAddr, seenBus);
    checkOutput("vfyGoodLatency", 64'(doneCyc), 64'd8);
    checkOutput("vfyErrSticky", 64'(verr), 64'h1);
`else
    checkOutput("verrTiedLow", 64'(verr), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Single-port asynchronous-SRAM controller that executes word read/write requests from a test or client FSM.
- Drives the external SRAM pins: address, bidirectional data, CE#/OE#/WE#.
- Returns read data and a one-cycle workdone pulse.
- Sits directly downstream of the RAM test client, consuming its toread/towrite/addr/to_data and producing get_data/workdone.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 32, SRAM data width.
- WAIT_CYC, 2, clk cycles of WE# low (write) or OE# access wait (read); values below 1 behave as 1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- toread  in  1  read request, level, held until workdone
- towrite  in  1  write request, level, held until workdone
- addr  in  ADDR_W  request word address
- to_data  in  DATA_W  write data
- get_data  out  DATA_W  last read data, registered
- workdone  out  1  one-cycle completion pulse
- busy  out  1  high whenever state is not IDLE
- verr  out  1  sticky write-verify error (see Optional Feature)
- sram_addr  out  ADDR_W  SRAM address, registered
- sram_data  inout  DATA_W  SRAM data bus
- sram_ce_n  out  1  chip enable, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_we_n  out  1  write enable, active-low

Behaviour:
- Reset is asynchronous, active-low; clock is clk.
- Reset values: state=IDLE, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_data=Z, sram_addr=0, get_data=0, workdone=0, busy=0, verr=0.
- All outputs are registered. sram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD; it is Z in every other state.
- States: IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_WAIT, DONE, RECOV; plus VRD_SETUP and VRD_WAIT with the Optional Feature.
- IDLE:
  - CE#, OE# and WE# are all 1.
  - On a clock edge, towrite=1 -> capture addr/to_data, go to WR_SETUP.
  - Else toread=1 -> capture addr, go to RD_SETUP.
  - Write has priority when both are asserted.
- WR_SETUP (1 cycle): sram_addr=captured address, data driven, CE#=0, WE#=1.
- WR_PULSE (WAIT_CYC cycles): WE#=0.
- WR_HOLD (1 cycle): WE#=1, data still driven. Then go to DONE.
- RD_SETUP (1 cycle): CE#=0, OE#=0.
- RD_WAIT (WAIT_CYC cycles): OE#=0. On the last edge of RD_WAIT, get_data<=sram_data. Then go to DONE.
- DONE (1 cycle): workdone=1, CE#/OE#/WE#=1.
- RECOV (1 cycle): requests are ignored, then return to IDLE. This absorbs the client's request line remaining high for one cycle after it sees workdone.
- Latency, counting from the acceptance edge in IDLE:
  - Write: workdone high in cycle 3+WAIT_CYC (5 at default).
  - Read: workdone high in cycle 2+WAIT_CYC (4 at default).
  - Minimum back-to-back spacing: next request is accepted 2 cycles after the workdone cycle.
- get_data holds its value until the next read completes. Writes never change get_data.
- addr and to_data changes after acceptance have no effect on the access in flight.
- A wait counter counts the WR_PULSE/RD_WAIT cycles. It is reloaded on state entry and never wraps.
- Reset mid-access: WE#, OE# and CE# go to 1 and the bus goes to Z immediately (asynchronously). No workdone is issued. The interrupted write contents are undefined.

Optional Feature:
- Macro: SRAM_WR_VERIFY_EN.
- Defined:
  - WR_HOLD goes to VRD_SETUP (1 cycle, OE#=0), then VRD_WAIT (WAIT_CYC cycles).
  - On the last VRD_WAIT edge, compare sram_data with the captured write data. On mismatch set verr=1; verr is sticky until reset.
  - Then go to DONE. Write latency grows by 1+WAIT_CYC (to 8 at default).
  - get_data is not updated by verify reads.
- Undefined: verify states are absent, verr is tied 0, write latency is as in Behaviour.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> all CE#/OE#/WE#=1, sram_data=Z, workdone=0, busy=0 for 10 cycles.
- Write: towrite=1, addr=0, to_data=0x00000005, held until workdone -> WE# low for exactly 2 cycles with sram_addr=0 and bus=0x5; workdone high in cycle 5 for 1 cycle.
- Read-after-write with an SRAM model holding 0x5 at address 0: toread=1 -> OE# low 3 cycles, workdone in cycle 4, get_data=0x00000005 and stable afterwards.
- Client overlap: keep towrite=1 for one cycle after workdone, then toread=1 -> no second write occurs (RECOV); the read is accepted in the next cycle.
- Priority and reset: toread=towrite=1 at addr 0x12345 -> write executes. Pulse rst=0 during WR_PULSE -> WE# returns to 1 asynchronously and no workdone is issued.
- With SRAM_WR_VERIFY_EN and a model that corrupts bit 0: write 0xA5A5A5A4 -> workdone in cycle 8, verr=1 and still 1 after a subsequent good write.
